mul_8bit_seq: RTL and testbench



---
 rtl/mul_8bit_seq_pkg.sv | 19 +
 rtl/adder_8bit.sv | 26 ++
 rtl/mul_8bit_seq.sv | 118 +++++++++++
 tb/tb_mul_8bit_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mul_8bit_seq_pkg.sv
// rtl/mul_8bit_seq_pkg.sv - shared state encoding and iteration constants for mul_8bit_seq
package mul_8bit_seq_pkg;

    // Operand width is fixed by the adder_8bit stage this block wraps.
    localparam int WIDTH      = 8;

    // One partial product per clock, one clock per multiplier bit.
    localparam int ITERATIONS = 8;

    // Counter value present at the edge that performs the final iteration.
    localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_8bit.sv
// rtl/adder_8bit.sv - 8-bit ripple-carry adder stage of the CPU datapath
module adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       C0,
    output logic [7:0] S,
    output logic       Overflow
);

    logic [8:0] w_carry;

    assign w_carry[0] = C0;

    // Ripple chain: each bit is a full adder fed by the previous carry.
    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_fa
            assign S[g]         = A[g] ^ B[g] ^ w_carry[g];
            assign w_carry[g+1] = (A[g] & B[g]) | (w_carry[g] & (A[g] ^ B[g]));
        end
    endgenerate

    // Carry-out of the top bit; for unsigned use this is bit 8 of the sum.
    assign Overflow = w_carry[8];

endmodule

// File: rtl/mul_8bit_seq.sv
// rtl/mul_8bit_seq.sv - sequential unsigned 8x8->16 shift-and-add multiplier
module mul_8bit_seq
    import mul_8bit_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P,
    output logic        busy,
    output logic        done
);

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_m;
    logic [7:0]  r_acc;
    logic [7:0]  r_q;
    logic [3:0]  r_cnt;
    logic [15:0] r_p;

    logic        w_load;
    logic        w_step;
    logic        w_last;

    logic [7:0]  w_addend;
    logic [7:0]  w_sum;
    logic        w_carry;
    logic [15:0] w_shifted;

    // Multiplicand contributes only when the current multiplier bit is set.
    assign w_addend = r_m & {WIDTH{r_q[0]}};

    adder_8bit u_adder (
        .A        (r_acc),
        .B        (w_addend),
        .C0       (1'b0),
        .S        (w_sum),
        .Overflow (w_carry)
    );

    // Carry lands in bit 15 so the partial never overflows; Q shifts out its used bit.
    assign w_shifted = {w_carry, w_sum, r_q[7:1]};

    assign w_last = (r_cnt == LAST_ITER);

    // State register; reset discards any in-flight operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: start is honoured only when not mid-calculation.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_CALC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture operands on load, shift-accumulate one bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_load) begin
            r_m   <= A;
            r_q   <= B;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_acc <= w_shifted[15:8];
            r_q   <= w_shifted[7:0];
            r_cnt <= r_cnt + 4'd1;
            if (w_last) begin
                r_p <= w_shifted;
            end
        end
    end

    // Status outputs decode the registered state only.
    assign busy = (r_state == ST_CALC);
    assign done = (r_state == ST_DONE);
    assign P    = r_p;

endmodule

// File: tb/tb_mul_8bit_seq.sv
// tb/tb_mul_8bit_seq.sv - self-checking bench for mul_8bit_seq
module tb_mul_8bit_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    mul_8bit_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Transaction model: a run lasts 8 cycles after acceptance, then a one-cycle done.
    int          m_left;
    logic [15:0] m_prod;
    logic [15:0] m_p;
    logic        m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_prod <= 16'h0;
            m_p    <= 16'h0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_left <= 8;
                    m_prod <= 16'(A) * 16'(B);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_p    <= m_prod;
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_P",    int'(P),    int'(m_p));
        check("cyc_busy", int'(busy), (m_left > 0) ? 1 : 0);
        check("cyc_done", int'(done), int'(m_done));
    end

    // One operation; optional mid-run start pulse with different operands at glitch_k.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input int glitch_k, input string name);
        int busy_cnt;
        int done_cnt;
        int done_at;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (k == glitch_k) begin
                start = 1'b1;
                A = ~a;
                B = ~b;
            end else if (k == glitch_k + 1) begin
                start = 1'b0;
            end
        end
        check({name, "_busy_cycles"}, busy_cnt, 8);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_done_latency"}, done_at, 9);
        check({name, "_P"}, int'(P), int'(exp));
        check({name, "_model_P"}, int'(m_p), int'(exp));
    endtask

    initial begin
        int d1;
        int d2;
        rst_n = 1'b0;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (20) @(posedge clk);
        #1;
        check("idle_P",    int'(P),    0);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);

        run_op(8'd13,  8'd11,  16'h008F, -5, "basic");
        run_op(8'hFF,  8'hFF,  16'hFE01, -5, "max");
        run_op(8'h00,  8'hA5,  16'h0000, -5, "zero");
        run_op(8'h01,  8'hA5,  16'h00A5, -5, "ident");
        run_op(8'h80,  8'h02,  16'h0100, -5, "carry_bit8");
        run_op(8'h12,  8'h34,  16'h03A8,  3, "start_mid_calc");

        // start held high: back-to-back runs of 3x7, one result every 9 cycles.
        @(posedge clk);
        #1;
        start = 1'b1;
        A = 8'd3;
        B = 8'd7;
        d1 = -1;
        d2 = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_P", int'(P), 16'h0015);
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        start = 1'b0;
        check("b2b_first_done", (d1 > 0) ? 1 : 0, 1);
        check("b2b_spacing", d2 - d1, 9);
        repeat (12) @(posedge clk);

        // Reset on the 4th CALC cycle must clear outputs without a clock edge.
        @(posedge clk);
        #1;
        start = 1'b1;
        A = 8'h55;
        B = 8'h66;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_P",    int'(P),    16'h0015);
        rst_n = 1'b0;
        #1;
        check("async_rst_P",    int'(P),    0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(8'd6, 8'd9, 16'h0036, -5, "after_rst");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
